// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller, ALU decoder and datapath.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEMADR   = 4'd3,
        S_MEMREAD  = 4'd4,
        S_MEMWB    = 4'd5,
        S_MEMWRITE = 4'd6,
        S_EXECUTE  = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_ADDIEXEC = 4'd10,
        S_ADDIWB   = 4'd11,
        S_JUMP     = 4'd12,
        S_TRAP     = 4'd15
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REGB    = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/mem_wait_watchdog.sv
// Counts memory wait cycles and flags when LIMIT waits have elapsed without completion.
// Latency: expired is registered count compare, valid the cycle after the LIMIT-th wait.
// Backpressure: none; saturates at LIMIT, LIMIT=0 never expires.
module mem_wait_watchdog #(
    parameter int unsigned LIMIT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam int W = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
    localparam logic [W-1:0] LIM = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en && (cnt != LIM)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expired = (LIMIT != 0) && (cnt == LIM);

endmodule

// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS main control FSM driving datapath enables and alu_op.
// Latency: 3-5 states per instruction plus memory wait cycles; outputs are Moore (mem_ready-gated in FETCH).
// Backpressure: holds in FETCH/MEMREAD/MEMWRITE until mem_ready; watchdog traps on a stuck memory.
module mips_multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       pc_en,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state_o
);

    state_t state, state_next;
    logic   set_illegal, set_timeout;
    logic   wd_expired;
    logic   pc_write, branch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            illegal_op  <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_next;
            illegal_op  <= illegal_op | set_illegal;
            mem_timeout <= mem_timeout | set_timeout;
        end
    end

    // Any state change restarts the wait count, so each access gets a full budget.
    mem_wait_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (state_next != state),
        .count_en (mem_req & ~mem_ready),
        .expired  (wd_expired)
    );

    always_comb begin
        state_next  = state;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH, S_MEMREAD, S_MEMWRITE: begin
                // Completion beats the watchdog when both land on the same cycle.
                if (mem_ready) begin
                    case (state)
                        S_FETCH:   state_next = S_DECODE;
                        S_MEMREAD: state_next = S_MEMWB;
                        default:   state_next = S_FETCH;
                    endcase
                end else if (wd_expired) begin
                    state_next  = S_TRAP;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTE;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_ADDI:      state_next = S_ADDIEXEC;
                    OP_J:         state_next = S_JUMP;
                    default: begin
                        state_next  = S_TRAP;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR:   state_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMWB:    state_next = S_FETCH;
            S_EXECUTE:  state_next = S_ALUWB;
            S_ALUWB:    state_next = S_FETCH;
            S_BRANCH:   state_next = S_FETCH;
            S_ADDIEXEC: state_next = S_ADDIWB;
            S_ADDIWB:   state_next = S_FETCH;
            S_JUMP:     state_next = S_FETCH;
            S_TRAP:     state_next = S_TRAP;
            default:    state_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req    = is_mem_state(state);
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALUOP_ADD;
        pc_src     = PCSRC_ALU;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (state)
            S_FETCH: begin
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:   alu_src_b = SRCB_IMM_SH2;
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  iord = 1'b1;
            S_MEMWB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                reg_dst   = 1'b1;
                reg_write = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_src    = PCSRC_ALUOUT;
                branch    = 1'b1;
            end
            S_ADDIEXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB:   reg_write = 1'b1;
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_en   = pc_write | (branch & zero);
    assign state_o = state;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Bench for mips_multicycle_controller: per-cycle expected state/outputs queued at drive time,
// popped and compared one time unit after each falling edge.
module tb_mips_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
    logic       alu_src_a, pc_en, illegal_op, mem_timeout;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state_o;

    int total = 0;
    int bad = 0;
    logic [20:0] sb[$];
    logic [20:0] obs;

    mips_multicycle_controller #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .reset_n(reset_n), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .pc_en(pc_en), .illegal_op(illegal_op), .mem_timeout(mem_timeout), .state_o(state_o)
    );

    always #5 clk = ~clk;

    assign obs = {state_o, illegal_op, mem_timeout, mem_req, iord, mem_write, ir_write, reg_dst,
                  mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, pc_src, pc_en};

    // Expected enables per state, straight from the controller's state table.
    function automatic logic [14:0] spec_outs(input logic [3:0] st, input logic mr, input logic z);
        logic mq, io, mw, irw, rd, m2r, rw, sa, pen;
        logic [1:0] srcb, ao, ps;
        {mq, io, mw, irw, rd, m2r, rw, sa, pen} = '0;
        srcb = 2'b00; ao = 2'b00; ps = 2'b00;
        case (st)
            4'd1:  begin mq = 1'b1; srcb = 2'b01; irw = mr; pen = mr; end
            4'd2:  srcb = 2'b11;
            4'd3:  begin sa = 1'b1; srcb = 2'b10; end
            4'd4:  begin mq = 1'b1; io = 1'b1; end
            4'd5:  begin m2r = 1'b1; rw = 1'b1; end
            4'd6:  begin mq = 1'b1; io = 1'b1; mw = 1'b1; end
            4'd7:  begin sa = 1'b1; ao = 2'b10; end
            4'd8:  begin rd = 1'b1; rw = 1'b1; end
            4'd9:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pen = z; end
            4'd10: begin sa = 1'b1; srcb = 2'b10; end
            4'd11: rw = 1'b1;
            4'd12: begin ps = 2'b10; pen = 1'b1; end
            default: ;
        endcase
        return {mq, io, mw, irw, rd, m2r, rw, sa, srcb, ao, ps, pen};
    endfunction

    // Step entry: expected state, mem_ready, zero, flags {illegal_op, mem_timeout}.
    function automatic logic [7:0] ent(input int st, input int mr, input int z, input int fl);
        return {4'(st), 1'(mr), 1'(z), 2'(fl)};
    endfunction

    task automatic drive_step(input logic [7:0] e);
        @(negedge clk);
        mem_ready = e[3];
        zero = e[2];
        sb.push_back({e[7:4], e[1], e[0], spec_outs(e[7:4], e[3], e[2])});
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [20:0] want;
        reset_n = 1'b0; mem_ready = 1'b1; zero = 1'b1; op = 6'b100011;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (obs !== 21'd0) begin bad++; $display("FAIL reset_hold got=%h want=%h", obs, 21'd0); end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++;
        if (obs !== 21'd0) begin bad++; $display("FAIL reset_release_idle got=%h want=%h", obs, 21'd0); end
        drive_step(ent(1, 1, 1, 0));
        want = sb.pop_front();
        total++;
        if (obs !== want) begin bad++; $display("FAIL first_fetch got=%h want=%h", obs, want); end
    endtask

    task automatic test_lw();
        logic [7:0] t [6];
        logic [20:0] want;
        op = 6'b100011; do_reset();
        t = '{ent(1,1,0,0), ent(2,1,0,0), ent(3,1,0,0), ent(4,1,0,0), ent(5,1,0,0), ent(1,1,0,0)};
        foreach (t[i]) begin
            drive_step(t[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL lw step=%0d got=%h want=%h", i, obs, want); end
        end
    endtask

    task automatic test_sw_wait();
        logic [7:0] t [8];
        logic [20:0] want;
        op = 6'b101011; do_reset();
        t = '{ent(1,1,0,0), ent(2,1,0,0), ent(3,1,0,0), ent(6,0,0,0),
              ent(6,0,0,0), ent(6,0,0,0), ent(6,1,0,0), ent(1,1,0,0)};
        foreach (t[i]) begin
            drive_step(t[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL sw_wait step=%0d got=%h want=%h", i, obs, want); end
        end
    endtask

    task automatic test_beq();
        logic [7:0] t [7];
        logic [20:0] want;
        op = 6'b000100; do_reset();
        t = '{ent(1,1,0,0), ent(2,1,0,0), ent(9,1,1,0), ent(1,1,0,0),
              ent(2,1,0,0), ent(9,1,0,0), ent(1,1,0,0)};
        foreach (t[i]) begin
            drive_step(t[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL beq step=%0d got=%h want=%h", i, obs, want); end
        end
    endtask

    task automatic test_alu_ops();
        logic [7:0] tr [5];
        logic [7:0] ta [5];
        logic [7:0] tj [4];
        logic [20:0] want;
        op = 6'b000000; do_reset();
        tr = '{ent(1,1,0,0), ent(2,1,1,0), ent(7,1,1,0), ent(8,1,0,0), ent(1,1,0,0)};
        foreach (tr[i]) begin
            drive_step(tr[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL rtype step=%0d got=%h want=%h", i, obs, want); end
        end
        op = 6'b001000; do_reset();
        ta = '{ent(1,1,0,0), ent(2,1,0,0), ent(10,1,0,0), ent(11,1,0,0), ent(1,1,0,0)};
        foreach (ta[i]) begin
            drive_step(ta[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL addi step=%0d got=%h want=%h", i, obs, want); end
        end
        op = 6'b000010; do_reset();
        tj = '{ent(1,1,0,0), ent(2,1,0,0), ent(12,0,0,0), ent(1,1,0,0)};
        foreach (tj[i]) begin
            drive_step(tj[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL jump step=%0d got=%h want=%h", i, obs, want); end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] t [5];
        logic [20:0] want;
        op = 6'b111111; do_reset();
        t = '{ent(1,1,0,0), ent(2,1,0,0), ent(15,1,1,2), ent(15,1,0,2), ent(15,0,1,2)};
        foreach (t[i]) begin
            drive_step(t[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL illegal step=%0d got=%h want=%h", i, obs, want); end
        end
        reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 21'd0) begin bad++; $display("FAIL illegal_cleared got=%h want=%h", obs, 21'd0); end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_timeout();
        logic [7:0] t [7];
        logic [7:0] tb2 [13];
        logic [20:0] want;
        op = 6'b100011; do_reset();
        t = '{ent(1,0,0,0), ent(1,0,0,0), ent(1,0,0,0), ent(1,0,0,0),
              ent(1,0,0,0), ent(15,0,0,1), ent(15,1,0,1)};
        foreach (t[i]) begin
            drive_step(t[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL timeout step=%0d got=%h want=%h", i, obs, want); end
        end
        // mem_ready on the limit cycle completes; the next access gets a fresh budget.
        do_reset();
        tb2 = '{ent(1,0,0,0), ent(1,0,0,0), ent(1,0,0,0), ent(1,0,0,0), ent(1,1,0,0),
                ent(2,1,0,0), ent(3,1,0,0), ent(4,0,0,0), ent(4,0,0,0), ent(4,0,0,0),
                ent(4,0,0,0), ent(4,1,0,0), ent(5,1,0,0)};
        foreach (tb2[i]) begin
            drive_step(tb2[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL timeout_edge step=%0d got=%h want=%h", i, obs, want); end
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] t [5];
        logic [20:0] want;
        op = 6'b101011; do_reset();
        t = '{ent(1,1,0,0), ent(2,1,0,0), ent(3,1,0,0), ent(6,0,0,0), ent(6,0,0,0)};
        foreach (t[i]) begin
            drive_step(t[i]);
            want = sb.pop_front();
            total++;
            if (obs !== want) begin bad++; $display("FAIL async_pre step=%0d got=%h want=%h", i, obs, want); end
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (obs !== 21'd0) begin bad++; $display("FAIL async_reset got=%h want=%h", obs, 21'd0); end
        @(negedge clk);
        reset_n = 1'b1;
        drive_step(ent(1, 1, 0, 0));
        want = sb.pop_front();
        total++;
        if (obs !== want) begin bad++; $display("FAIL async_restart got=%h want=%h", obs, want); end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_beq();
        test_alu_ops();
        test_illegal();
        test_timeout();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL sim_time_limit total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit reached");
    end

endmodule
